// File: rtl/tick_rate_if.sv
// Tick stream in, recovered rate/count out.
// master = tick source side, slave = decoder.
interface tick_rate_if #(
  parameter int CW = 12
);
  logic          tick_in;
  logic [1:0]    speed_code;
  logic          speed_valid;
  logic          err;
  logic          timeout;
  logic [CW-1:0] period_out;
  logic [3:0]    tick_count;

  modport master (
    output tick_in,
    input  speed_code,
    input  speed_valid,
    input  err,
    input  timeout,
    input  period_out,
    input  tick_count
  );

  modport slave (
    input  tick_in,
    output speed_code,
    output speed_valid,
    output err,
    output timeout,
    output period_out,
    output tick_count
  );
endinterface

// File: rtl/tick_rate_decoder.sv
// Measures tick spacing, recovers the divider speed
// code and mirrors the producer's 4-bit tick count.
module tick_rate_decoder #(
  parameter int CW     = 12,
  parameter int P1     = 500,
  parameter int P2     = 1000,
  parameter int P3     = 2000,
  parameter int TOL    = 8,
  parameter int LOCK_N = 2
) (
  input  logic        clk,
  input  logic        resetn,
  tick_rate_if.slave  bus
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [CW:0]   P1_LO = (CW+1)'(P1 - TOL);
  localparam logic [CW:0]   P1_HI = (CW+1)'(P1 + TOL);
  localparam logic [CW:0]   P2_LO = (CW+1)'(P2 - TOL);
  localparam logic [CW:0]   P2_HI = (CW+1)'(P2 + TOL);
  localparam logic [CW:0]   P3_LO = (CW+1)'(P3 - TOL);
  localparam logic [CW:0]   P3_HI = (CW+1)'(P3 + TOL);
  localparam logic [CW-1:0] TMO   = CW'(P3 + TOL);
  localparam logic [MW:0]   LOCKV = (MW+1)'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    cand_q, cand_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [1:0]    code_q, code_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] per_q, per_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          tick;
  logic [CW:0]   period;
  logic          cls_ok;
  logic [1:0]    cls;
  logic [MW:0]   mcnt_inc;

  assign tick     = bus.tick_in;
  assign period   = {1'b0, pcnt_q} + 1'b1;
  assign mcnt_inc = {1'b0, mcnt_q} + 1'b1;

  // Map the just-finished period onto a speed class.
  always_comb begin
    cls_ok = 1'b1;
    cls    = 2'd0;
    if (period == (CW+1)'(1)) begin
      cls = 2'd0;
    end else if (period >= P1_LO && period <= P1_HI) begin
      cls = 2'd1;
    end else if (period >= P2_LO && period <= P2_HI) begin
      cls = 2'd2;
    end else if (period >= P3_LO && period <= P3_HI) begin
      cls = 2'd3;
    end else begin
      cls_ok = 1'b0;
    end
  end

  // Lock FSM, period counter and output next-values.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q + 1'b1;
    cand_d  = cand_q;
    mcnt_d  = mcnt_q;
    code_d  = code_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    per_d   = per_q;
    cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    unique case (state_q)
      S_IDLE: begin
        pcnt_d = '0;
        if (tick) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (tick) begin
          pcnt_d = '0;
          per_d  = period[CW-1:0];
          if (!cls_ok) begin
            err_d  = 1'b1;
            mcnt_d = '0;
          end else if (cls == cand_q) begin
            mcnt_d = mcnt_inc[MW-1:0];
            if (mcnt_inc == LOCKV) begin
              state_d = S_LOCKED;
              code_d  = cand_q;
            end
          end else begin
            cand_d = cls;
            mcnt_d = MW'(1);
          end
        end else if (pcnt_q == TMO) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          mcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_LOCKED: begin
        if (tick) begin
          pcnt_d = '0;
          per_d  = period[CW-1:0];
          if (!cls_ok || cls != code_q) begin
            err_d   = 1'b1;
            state_d = S_MEAS;
            if (cls_ok) begin
              cand_d = cls;
              mcnt_d = MW'(1);
            end else begin
              mcnt_d = '0;
            end
          end
        end else if (pcnt_q == TMO) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          mcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      cand_q  <= '0;
      mcnt_q  <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      per_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cand_q  <= cand_d;
      mcnt_q  <= mcnt_d;
      code_q  <= code_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.speed_code  = code_q;
  assign bus.speed_valid = (state_q == S_LOCKED);
  assign bus.err         = err_q;
  assign bus.timeout     = tmo_q;
  assign bus.period_out  = per_q;
  assign bus.tick_count  = cnt_q;

endmodule
